aib_tx_arbiter: RTL and testbench
=================================

// Module: aib_tx_arbiter
// PURPOSE
//  Shares the channel adapter Tx port (valid/ready, 72-bit data) among NUM_REQ requesters.
//  Arbitration is round-robin and packet-locked: a grant holds until that requester's last beat is accepted.
//  A one-stage register slice drives the adapter port, so arbitration logic stays off the adapter timing path.
//  Sits between the client logic and the adapter Tx inputs, in the i_aib_clk domain.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DATA_W   72  beat width; must equal the adapter Tx data width
//  CNT_W    16  width of each statistics counter (used only with AIB_TX_ARB_STATS_EN)
// PORTS
//  i_aib_clk     in   1                  clock; the only clock
//  i_rst_n       in   1                  asynchronous active-low reset
//  c_req_en      in   NUM_REQ            per-requester enable mask (quasi-static)
//  i_req_valid   in   NUM_REQ            requester beat valid
//  i_req_last    in   NUM_REQ            marks the final beat of a packet
//  i_req_data    in   NUM_REQ x DATA_W   requester beat data
//  o_req_ready   out  NUM_REQ            beat accepted from requester when valid&ready
//  o_tx_valid    out  1                  to adapter i_tx_valid
//  i_tx_ready    in   1                  from adapter o_tx_ready
//  o_tx_data     out  DATA_W             to adapter i_tx_data
//  o_grant_id    out  $clog2(NUM_REQ)    currently locked requester (valid when o_busy)
//  o_busy        out  1                  high while in the LOCKED state
//  o_beat_cnt    out  NUM_REQ x CNT_W    per-requester accepted-beat counters
// BEHAVIOUR
//  Reset values: o_tx_valid=0, o_tx_data=0, o_req_ready=0, o_grant_id=0, o_busy=0, o_beat_cnt=0.
//    Round-robin pointer resets to 0, so requester 0 has highest priority.
//  Slice: slot_free = !o_tx_valid | i_tx_ready. The slice loads when a granted beat is accepted.
//    If no beat is accepted in a cycle where i_tx_ready=1, o_tx_valid clears.
//    Latency: requester accept -> o_tx_valid is 1 cycle. Full throughput: 1 beat/cycle sustained.
//  FSM (2 states):
//    IDLE: candidates = i_req_valid & c_req_en. Pick the first set bit at or after ptr, wrapping.
//      If a candidate exists and slot_free, accept its beat in the same cycle (o_req_ready one-hot, combinational).
//      If that beat is not last -> LOCKED, o_grant_id = winner.
//      If that beat is last (single-beat packet) -> stay IDLE, ptr = winner+1 mod NUM_REQ.
//    LOCKED: o_req_ready[grant] = slot_free; every other ready bit is 0.
//      When the last beat is accepted -> IDLE, ptr = grant+1 mod NUM_REQ.
//      A gap (i_req_valid low) holds the lock; no other requester interleaves.
//  o_req_ready is never asserted while slot_free=0. At most one ready bit is high per cycle.
//  c_req_en deasserted for a requester that holds the lock: the lock holds until its last beat.
//    Masking takes effect at the next arbitration.
//  All candidates masked or idle: no grant, and ptr is unchanged.
//  ptr wraps from NUM_REQ-1 to 0.
//  Asynchronous reset mid-packet: state -> IDLE and the slice is emptied.
//    The partial packet is dropped; requesters must also be reset.
// CONFIGURATION
//  Macro AIB_TX_ARB_STATS_EN:
//    Defined: o_beat_cnt[i] increments on each accepted beat of requester i and saturates at 2^CNT_W-1.
//    Not defined: o_beat_cnt is tied to 0 and no counter flops are inferred.
//  c_req_en is driven from the channel configuration registers alongside the other c_* controls.
// STRUCTURE
//  Package aib_tx_arb_pkg:
//    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
//    localparam AIB_DATA_W = 72.
//  Sub-module aib_rr_pick: combinational round-robin picker.
//    Inputs: req vector, ptr. Outputs: one-hot grant, encoded id, any.
//  Top level holds the FSM, ptr, grant register, slice and the optional counters.
// TESTING
//  1. Reset, then req0 sends a 1-beat packet (data 0xA5, last=1), ready=1
//     -> o_tx_valid with data 0xA5 one cycle later; ptr=1.
//  2. Req0 and req2 both valid with 3-beat packets
//     -> req0's 3 beats are contiguous on o_tx_data, then req2's 3 beats; no interleave.
//  3. Req1 holds the lock; req1 valid drops for 2 cycles mid-packet while req3 is valid
//     -> o_req_ready[3] stays 0 until req1's last beat is accepted.
//  4. i_tx_ready held 0 for 5 cycles with a full slice
//     -> o_tx_data stable, o_tx_valid=1, all o_req_ready=0.
//     Ready returns -> beats resume with no loss or duplication.
//  5. All 4 requesters continuously sending 1-beat packets, c_req_en=4'b1011
//     -> grant order 0,1,3,0,1,3; requester 2 never granted.
//  6. i_rst_n pulsed low in the middle of a 4-beat packet
//     -> outputs return to reset values immediately; the next grant goes to req0.
//     With AIB_TX_ARB_STATS_EN: counters read 0 after reset; CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/aib_tx_arb_pkg.sv
// Shared types and helpers for the AIB Tx arbiter slice.
package aib_tx_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   localparam int unsigned AIB_DATA_W = 72;

   function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
      return (id + 1 == n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/aib_tx_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module aib_rr_pick
   import aib_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] id_o,
   output logic                       any_o
);

   localparam int unsigned IDW = $clog2(NUM_REQ);

   int unsigned idx;

   always_comb begin
      grant_o = '0;
      id_o    = '0;
      any_o   = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(ptr_i) + i) % NUM_REQ;
         if (!any_o && req_i[IDW'(idx)]) begin
            any_o             = 1'b1;
            id_o              = IDW'(idx);
            grant_o[IDW'(idx)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aib_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding the adapter Tx port through a one-stage slice.
// Optional per-requester beat counters: define AIB_TX_ARB_STATS_EN.
module aib_tx_arbiter
   import aib_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = AIB_DATA_W,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                              i_aib_clk,
   input  logic                              i_rst_n,
   input  logic [NUM_REQ-1:0]                c_req_en,
   input  logic [NUM_REQ-1:0]                i_req_valid,
   input  logic [NUM_REQ-1:0]                i_req_last,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]    i_req_data,
   output logic [NUM_REQ-1:0]                o_req_ready,
   output logic                              o_tx_valid,
   input  logic                              i_tx_ready,
   output logic [DATA_W-1:0]                 o_tx_data,
   output logic [$clog2(NUM_REQ)-1:0]        o_grant_id,
   output logic                              o_busy,
   output logic [NUM_REQ-1:0][CNT_W-1:0]     o_beat_cnt
);

   localparam int unsigned IDW = $clog2(NUM_REQ);

   arb_state_t         state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d, grant_q, grant_d, sel_id, pick_id;
   logic [NUM_REQ-1:0] pick_onehot, req_ready, acc_vec;
   logic               pick_any, slot_free, accept;
   logic               tx_valid_q;
   logic [DATA_W-1:0]  tx_data_q;

   assign slot_free = !tx_valid_q || i_tx_ready;

   aib_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (i_req_valid & c_req_en),
      .ptr_i   (ptr_q),
      .grant_o (pick_onehot),
      .id_o    (pick_id),
      .any_o   (pick_any)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      sel_id    = grant_q;
      req_ready = '0;
      case (state_q)
         ARB_IDLE: begin
            sel_id = pick_id;
            if (pick_any && slot_free) begin
               req_ready = pick_onehot;
               if (i_req_last[pick_id]) begin
                  ptr_d = IDW'(rr_next(32'(pick_id), NUM_REQ));
               end else begin
                  state_d = ARB_LOCKED;
                  grant_d = pick_id;
               end
            end
         end
         ARB_LOCKED: begin
            // The lock ignores c_req_en; masking only affects the next arbitration.
            req_ready[grant_q] = slot_free;
            if (slot_free && i_req_valid[grant_q] && i_req_last[grant_q]) begin
               state_d = ARB_IDLE;
               ptr_d   = IDW'(rr_next(32'(grant_q), NUM_REQ));
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Gated so no beat is handshaken while reset is held.
   assign o_req_ready = req_ready & {NUM_REQ{i_rst_n}};
   assign acc_vec     = o_req_ready & i_req_valid;
   assign accept      = |acc_vec;

   always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else if (accept) begin
         tx_valid_q <= 1'b1;
         tx_data_q  <= i_req_data[sel_id];
      end else if (i_tx_ready) begin
         tx_valid_q <= 1'b0;
      end
   end

   assign o_tx_valid = tx_valid_q;
   assign o_tx_data  = tx_data_q;
   assign o_grant_id = grant_q;
   assign o_busy     = (state_q == ARB_LOCKED);

`ifdef AIB_TX_ARB_STATS_EN
   logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (acc_vec[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
   end

   always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign o_beat_cnt = cnt_q;
`else
   assign o_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_aib_tx_arbiter.sv
// Self-checking bench for aib_tx_arbiter: directed scenarios plus randomized traffic against a queue-level model.
module tb_aib_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 72;
`ifdef AIB_TX_ARB_STATS_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0]          c_req_en = '1;
   logic [N-1:0]          req_valid = '0;
   logic [N-1:0]          req_last = '0;
   logic [N-1:0][DW-1:0]  req_data = '0;
   logic [N-1:0]          req_ready;
   logic                  tx_valid;
   logic                  tx_ready = 1'b1;
   logic [DW-1:0]         tx_data;
   logic [1:0]            grant_id;
   logic                  busy;
   logic [N-1:0][CW-1:0]  beat_cnt;

   aib_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .i_aib_clk   (clk),
      .i_rst_n     (rst_n),
      .c_req_en    (c_req_en),
      .i_req_valid (req_valid),
      .i_req_last  (req_last),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .o_tx_valid  (tx_valid),
      .i_tx_ready  (tx_ready),
      .o_tx_data   (tx_data),
      .o_grant_id  (grant_id),
      .o_busy      (busy),
      .o_beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model state: who holds the lock, where the round-robin pointer is, what sits in the slice.
   int            m_owner = -1;
   int            m_ptr   = 0;
   logic          m_txv   = 1'b0;
   logic [DW-1:0] m_txd   = '0;
   int            m_cnt[N];
   logic [DW-1:0] acc_log[$];
   logic [DW-1:0] out_log[$];
   int            w, c;
   logic          sf;
   logic [N-1:0]  exp_rdy;
   logic [N-1:0][CW-1:0] exp_cnt;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_txv = 1'b0; m_txd = '0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         check_eq("rst_tx_valid", 128'(tx_valid), 128'(0));
         check_eq("rst_tx_data", 128'(tx_data), 128'(0));
         check_eq("rst_req_ready", 128'(req_ready), 128'(0));
         check_eq("rst_busy", 128'(busy), 128'(0));
         check_eq("rst_grant_id", 128'(grant_id), 128'(0));
         check_eq("rst_beat_cnt", 128'(beat_cnt), 128'(0));
      end else begin
         sf = !m_txv || tx_ready;
         w  = -1;
         if (m_owner >= 0) w = m_owner;
         else begin
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (req_valid[c] && c_req_en[c]) begin w = c; break; end
            end
         end
         exp_rdy = '0;
         if (w >= 0 && sf) exp_rdy[w] = 1'b1;
         for (int r = 0; r < N; r++) exp_cnt[r] = CW'(m_cnt[r]);
         check_eq("req_ready", 128'(req_ready), 128'(exp_rdy));
         check_eq("tx_valid", 128'(tx_valid), 128'(m_txv));
         if (m_txv) check_eq("tx_data", 128'(tx_data), 128'(m_txd));
         check_eq("busy", 128'(busy), 128'(m_owner >= 0));
         if (m_owner >= 0) check_eq("grant_id", 128'(grant_id), 128'(m_owner));
         check_eq("beat_cnt", 128'(beat_cnt), 128'(exp_cnt));
         if (m_txv && tx_ready) out_log.push_back(m_txd);
         if (w >= 0 && sf && req_valid[w]) begin
            acc_log.push_back(DW'(w));
            m_txv = 1'b1;
            m_txd = req_data[w];
            if (req_last[w]) begin m_owner = -1; m_ptr = (w + 1) % N; end
            else m_owner = w;
`ifdef AIB_TX_ARB_STATS_EN
            if (m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
`endif
         end else if (tx_ready) begin
            m_txv = 1'b0;
         end
      end
   end

   // Requester side: per-requester packet queues presented beat by beat.
   beat_t        q[N][$];
   logic [N-1:0] gap_mask  = '0;
   bit           rand_mode = 1'b0;
   logic [N-1:0] acc_snap;

   task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = base + DW'(i);
         b.l = (i == len - 1);
         q[r].push_back(b);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      acc_snap = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) if (acc_snap[r] && q[r].size() > 0) void'(q[r].pop_front());
      if (rand_mode) tx_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < N; r++) begin
         if (q[r].size() > 0 && !gap_mask[r] && (!rand_mode || $urandom_range(0, 4) != 0)) begin
            req_valid[r] = 1'b1;
            req_data[r]  = q[r][0].d;
            req_last[r]  = q[r][0].l;
         end else begin
            req_valid[r] = 1'b0;
            req_last[r]  = 1'b0;
         end
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      for (int r = 0; r < N; r++) q[r].delete();
      gap_mask = '0; req_valid = '0; req_last = '0;
      tick();
      tick();
      rst_n = 1'b1;
      acc_log.delete();
      out_log.delete();
   endtask

   task automatic run_until_idle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         done = (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) && (req_valid == '0) && !tx_valid;
      end
      check_eq("drain_timeout", 128'(done), 128'(1));
   endtask

   task automatic check_seq(input string name, input logic [DW-1:0] got[$], input logic [DW-1:0] exp[$], input bit exact);
      if (exact) check_eq({name, "_len"}, 128'(got.size()), 128'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         check_eq(name, (i < got.size()) ? 128'(got[i]) : '1, 128'(exp[i]));
   endtask

   initial begin
      logic [DW-1:0] e[$];
      logic [95:0]   rnd;

      // 1: single-beat packet, one-cycle latency, pointer moves past requester 0
      reset_dut();
      push_pkt(0, 1, 72'hA5);
      tick(); tick();
      check_eq("t1_tx_valid", 128'(tx_valid), 128'(1));
      check_eq("t1_tx_data", 128'(tx_data), 128'h0A5);
      push_pkt(0, 1, 72'hB0);
      push_pkt(1, 1, 72'hB1);
      tick(); tick();
      e = {72'd0, 72'd1};
      check_seq("t1_grant_order", acc_log, e, 1'b1);

      // 2: two 3-beat packets go out contiguously
      reset_dut();
      push_pkt(0, 3, 72'h01);
      push_pkt(2, 3, 72'h21);
      run_until_idle(50);
      e = {72'h01, 72'h02, 72'h03, 72'h21, 72'h22, 72'h23};
      check_seq("t2_out", out_log, e, 1'b1);

      // 3: a gap inside the locked packet does not let requester 3 in
      reset_dut();
      push_pkt(1, 4, 72'h10);
      push_pkt(3, 1, 72'h30);
      tick();
      gap_mask[1] = 1'b1;
      tick(); tick();
      gap_mask[1] = 1'b0;
      run_until_idle(50);
      e = {72'd1, 72'd1, 72'd1, 72'd1, 72'd3};
      check_seq("t3_grant_order", acc_log, e, 1'b1);

      // 4: adapter stalls with a full slice
      reset_dut();
      tx_ready = 1'b0;
      push_pkt(0, 2, 72'h11);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("t4_stall_valid", 128'(tx_valid), 128'(1));
         check_eq("t4_stall_data", 128'(tx_data), 128'h11);
         check_eq("t4_stall_ready", 128'(req_ready), 128'(0));
      end
      tx_ready = 1'b1;
      run_until_idle(50);
      e = {72'h11, 72'h12};
      check_seq("t4_out", out_log, e, 1'b1);

      // 5: requester 2 masked, others stream single-beat packets
      reset_dut();
      c_req_en = 4'b1011;
      for (int r = 0; r < N; r++) for (int k = 0; k < 4; k++) push_pkt(r, 1, DW'(8'h50 + 8'(r)));
      for (int i = 0; i < 7; i++) tick();
      e = {72'd0, 72'd1, 72'd3, 72'd0, 72'd1, 72'd3};
      check_seq("t5_grant_order", acc_log, e, 1'b0);
      c_req_en = '1;

      // 6: reset pulse in the middle of a 4-beat packet
      reset_dut();
      push_pkt(1, 4, 72'h40);
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_valid", 128'(tx_valid), 128'(0));
      check_eq("t6_async_busy", 128'(busy), 128'(0));
      check_eq("t6_async_ready", 128'(req_ready), 128'(0));
      check_eq("t6_async_cnt", 128'(beat_cnt), 128'(0));
      reset_dut();
      push_pkt(0, 1, 72'h70);
      push_pkt(2, 1, 72'h72);
      tick(); tick();
      e = {72'd0};
      check_seq("t6_first_grant", acc_log, e, 1'b0);

      // Randomized traffic with stalls, gaps, mask changes and one mid-run reset
      reset_dut();
      rand_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) c_req_en = 4'($urandom_range(0, 15));
         if (i == 1500) reset_dut();
         for (int r = 0; r < N; r++) begin
            if (q[r].size() == 0 && $urandom_range(0, 2) == 0) begin
               rnd = {$urandom, $urandom, $urandom};
               push_pkt(r, int'($urandom_range(1, 5)), rnd[DW-1:0]);
            end
         end
         tick();
      end
      rand_mode = 1'b0;
      c_req_en  = '1;
      tx_ready  = 1'b1;
      run_until_idle(300);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
